// File: rtl/b2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per clock.
// Optional macro B2BCD_NDIGITS_EN adds the ndig significant-digit count output.
module b2bcd_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [WIDTH-1:0]                 inp,
  output logic                             busy,
  output logic                             done,
  output logic [4*DIGITS-1:0]              outp
`ifdef B2BCD_NDIGITS_EN
  ,
  output logic [$clog2(DIGITS+1)-1:0]      ndig
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam int NW = $clog2(DIGITS + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state_reg;
  logic [BW-1:0]       bcd_reg;
  logic [WIDTH-1:0]    bin_reg;
  logic [CW-1:0]       cnt_reg;

  logic [BW-1:0]       bcd_adj;
  logic [BW+WIDTH-1:0] shifted;
  logic [BW-1:0]       bcd_shift;
  logic [WIDTH-1:0]    bin_shift;

  // Add-3 correction on every nibble in parallel, ahead of the shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 :
                                  bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign shifted   = {bcd_adj, bin_reg} << 1;
  assign bcd_shift = shifted[BW+WIDTH-1:WIDTH];
  assign bin_shift = shifted[WIDTH-1:0];

`ifdef B2BCD_NDIGITS_EN
  logic [NW-1:0] ndig_calc;

  // Highest non-zero nibble wins; a zero result still shows one digit.
  always_comb begin
    ndig_calc = NW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_shift[4*i +: 4] != 4'd0) ndig_calc = NW'(i + 1);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      bcd_reg   <= '0;
      bin_reg   <= '0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      outp      <= '0;
`ifdef B2BCD_NDIGITS_EN
      ndig      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_reg   <= inp;
            bcd_reg   <= '0;
            cnt_reg   <= CW'(WIDTH);
            busy      <= 1'b1;
            state_reg <= CONV;
          end
        end
        CONV: begin
          bcd_reg <= bcd_shift;
          bin_reg <= bin_shift;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            outp      <= bcd_shift;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
`ifdef B2BCD_NDIGITS_EN
            ndig      <= ndig_calc;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_b2bcd_seq_ctrl.sv
// Randomized self-checking bench for b2bcd_seq_ctrl (8-bit/3-digit and 4-bit/2-digit builds).
// Expected results come from plain decimal arithmetic on the operand.
module tb_b2bcd_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  inp = '0;
  logic        busy, done;
  logic [11:0] outp;

  logic        start4 = 1'b0;
  logic [3:0]  inp4 = '0;
  logic        busy4, done4;
  logic [7:0]  outp4;

`ifdef B2BCD_NDIGITS_EN
  logic [1:0]  ndig;
  logic [1:0]  ndig4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  b2bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .inp(inp),
    .busy(busy), .done(done), .outp(outp)
`ifdef B2BCD_NDIGITS_EN
    , .ndig(ndig)
`endif
  );

  b2bcd_seq_ctrl #(.WIDTH(4), .DIGITS(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .inp(inp4),
    .busy(busy4), .done(done4), .outp(outp4)
`ifdef B2BCD_NDIGITS_EN
    , .ndig(ndig4)
`endif
  );

  // Decimal value packed one digit per nibble.
  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r = '0;
    for (int d = 0; d < 3; d++) r[4*d +: 4] = 4'((v / (10 ** d)) % 10);
    return r;
  endfunction

  function automatic int ref_ndig(input int v);
    if (v >= 100) return 3;
    if (v >= 10) return 2;
    return 1;
  endfunction

  // Pulses start for one cycle, then counts edges until done (bounded).
  task automatic do_conv(input logic [7:0] v, output int lat);
    @(posedge clk); #1;
    start = 1'b1; inp = v;
    @(posedge clk); #1;
    start = 1'b0; inp = 8'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || outp !== 12'h000) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b outp=%h required 0 0 000", busy, done, outp);
    end
`ifdef B2BCD_NDIGITS_EN
    checks++;
    if (ndig !== 2'd0) begin
      errors++;
      $display("FAIL reset_ndig: ndig=%0d required 0", ndig);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset: busy=%b done=%b outp=%h", busy, done, outp);
  endtask

  task automatic test_directed;
    int vals[4] = '{0, 255, 99, 100};
    int lat;
    foreach (vals[i]) begin
      do_conv(8'(vals[i]), lat);
      $display("directed: inp=%0d outp=%h latency=%0d", vals[i], outp, lat);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL directed_latency: inp=%0d latency=%0d required 8", vals[i], lat);
      end
      checks++;
      if (outp !== ref_bcd(vals[i])) begin
        errors++;
        $display("FAIL directed_outp: inp=%0d outp=%h required %h", vals[i], outp, ref_bcd(vals[i]));
      end
`ifdef B2BCD_NDIGITS_EN
      checks++;
      if (int'(ndig) !== ref_ndig(vals[i])) begin
        errors++;
        $display("FAIL directed_ndig: inp=%0d ndig=%0d required %0d", vals[i], ndig, ref_ndig(vals[i]));
      end
`endif
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || outp !== ref_bcd(vals[i])) begin
        errors++;
        $display("FAIL done_width: done=%b outp=%h required 0 %h", done, outp, ref_bcd(vals[i]));
      end
    end
  endtask

  task automatic test_random;
    int lat;
    int v;
    for (int n = 0; n < 24; n++) begin
      v = int'($urandom_range(0, 255));
      do_conv(8'(v), lat);
      $display("random: inp=%0d outp=%h latency=%0d", v, outp, lat);
      checks++;
      if (lat !== 8 || outp !== ref_bcd(v)) begin
        errors++;
        $display("FAIL random: inp=%0d outp=%h lat=%0d required %h lat=8", v, outp, lat, ref_bcd(v));
      end
`ifdef B2BCD_NDIGITS_EN
      checks++;
      if (int'(ndig) !== ref_ndig(v)) begin
        errors++;
        $display("FAIL random_ndig: inp=%0d ndig=%0d required %0d", v, ndig, ref_ndig(v));
      end
`endif
    end
  endtask

  task automatic test_ignore_start;
    int ndone = 0;
    int v1, v2;
    v1 = int'($urandom_range(0, 255));
    v2 = (v1 + 1 + int'($urandom_range(0, 200))) % 256;
    @(posedge clk); #1;
    start = 1'b1; inp = 8'(v1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; inp = 8'(v2);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    $display("ignore_start: first=%0d second=%0d outp=%h dones=%0d", v1, v2, outp, ndone);
    checks++;
    if (ndone !== 1 || outp !== ref_bcd(v1)) begin
      errors++;
      $display("FAIL ignore_start: dones=%0d outp=%h required 1 %h", ndone, outp, ref_bcd(v1));
    end
  endtask

  task automatic test_back_to_back;
    int t[$];
    logic [11:0] r[$];
    int bad_busy = 0;
    @(posedge clk); #1;
    start = 1'b1; inp = 8'd37;
    @(posedge clk); #1;
    inp = 8'd200;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy === done) bad_busy++;
      if (done) begin t.push_back(k); r.push_back(outp); end
    end
    start = 1'b0;
    for (int k = 0; k < 20 && (busy || done); k++) @(posedge clk);
    #1;
    $display("back_to_back: dones=%0d busy_violations=%0d", t.size(), bad_busy);
    checks++;
    if (t.size() < 2) begin
      errors++;
      $display("FAIL back_to_back_count: dones=%0d required 2", t.size());
    end else begin
      checks++;
      if (t[1] - t[0] !== 9 || r[0] !== 12'h037 || r[1] !== 12'h200) begin
        errors++;
        $display("FAIL back_to_back: gap=%0d outp=%h,%h required 9 037,200", t[1] - t[0], r[0], r[1]);
      end
    end
    checks++;
    if (bad_busy !== 0) begin
      errors++;
      $display("FAIL back_to_back_busy: violations=%0d required 0", bad_busy);
    end
  endtask

  task automatic test_async_reset;
    int ndone = 0;
    int lat;
    @(posedge clk); #1;
    start = 1'b1; inp = 8'd123;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    $display("async_reset: busy=%b done=%b outp=%h", busy, done, outp);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || outp !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b outp=%h required 0 0 000", busy, done, outp);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL async_reset_nodone: dones=%0d required 0", ndone);
    end
    do_conv(8'd58, lat);
    $display("after_reset: inp=58 outp=%h latency=%0d", outp, lat);
    checks++;
    if (lat !== 8 || outp !== 12'h058) begin
      errors++;
      $display("FAIL after_reset: outp=%h lat=%0d required 058 8", outp, lat);
    end
  endtask

  task automatic test_sweep4;
    int lat;
    logic [11:0] exp;
    for (int v = 0; v < 16; v++) begin
      @(posedge clk); #1;
      start4 = 1'b1; inp4 = 4'(v);
      @(posedge clk); #1;
      start4 = 1'b0; inp4 = 4'($urandom);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (done4) begin lat = k; break; end
      end
      exp = ref_bcd(v);
      $display("sweep4: inp=%0d outp=%h latency=%0d", v, outp4, lat);
      checks++;
      if (lat !== 4 || outp4 !== exp[7:0]) begin
        errors++;
        $display("FAIL sweep4: inp=%0d outp=%h lat=%0d required %h 4", v, outp4, lat, exp[7:0]);
      end
`ifdef B2BCD_NDIGITS_EN
      checks++;
      if (int'(ndig4) !== ref_ndig(v)) begin
        errors++;
        $display("FAIL sweep4_ndig: inp=%0d ndig=%0d required %0d", v, ndig4, ref_ndig(v));
      end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_ignore_start;
    test_back_to_back;
    test_async_reset;
    test_sweep4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b2bcd_seq_ctrl.md
Name: b2bcd_seq_ctrl

Overview:
Sequential binary-to-BCD conversion controller using shift-and-add-3 (double dabble). It accepts a WIDTH-bit binary word through a start/busy/done handshake and runs one shift-add iteration per clock. It returns DIGITS packed BCD digits. It replaces the combinational 4-bit converter wherever wider operands (counters, ADC codes, display values) must be shown in decimal.

Parameters:
- WIDTH, 8, binary input width (2..16).
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1. Otherwise the upper digits are truncated and this is undefined usage.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request a conversion; sampled only in IDLE.
- inp  input  WIDTH  binary operand; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when outp updates.
- outp  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0]; holds its value between conversions.

Behaviour:
- Reset is asynchronous on rst high, with clk as the only clock:
  - state=IDLE, busy=0, done=0, outp=0, internal shift register and iteration counter = 0.
  - Reset mid-conversion aborts it; no done pulse follows.
- Internal state:
  - Shift register {bcd[4*DIGITS-1:0], bin[WIDTH-1:0]}.
  - Iteration counter of width $clog2(WIDTH+1).
- State IDLE:
  - busy=0.
  - If start=1 at a rising edge: load bin<=inp, bcd<=0, cnt<=WIDTH; go to CONV; busy=1 from the next cycle.
- State CONV, each edge:
  - Every BCD nibble >=5 gets +3 (all nibbles in parallel, combinationally).
  - Then the whole register shifts left by 1; cnt<=cnt-1.
  - On the edge where cnt==1, the final shifted bcd field is written to outp, done<=1, busy<=0, and the state returns to IDLE.
- Latency:
  - Start sampled at edge E0; outp valid and done=1 after edge E0+WIDTH.
  - Throughput is one conversion per WIDTH+1 cycles; back-to-back is allowed (see below).
- done:
  - Exactly one cycle wide.
  - Deasserts on the next edge unless the next conversion also completes there, which is impossible for WIDTH>=2.
- Start rules:
  - start while busy=1 is ignored; it is not queued and inp is not re-captured.
  - start high in the done cycle is accepted, since the state is already IDLE; the done pulse is still delivered.
  - start held high continuously gives repeated conversions.
- inp may change freely after the accepting edge; the result reflects the captured value only.
- Arithmetic:
  - The add-3 correction applies only before a shift, never after the final shift.
  - Every nibble of outp is in the range 0..9 for all legal inputs.

Optional Feature:
- Macro: B2BCD_NDIGITS_EN.
- When defined:
  - Adds output ndig, width $clog2(DIGITS+1): the count of significant decimal digits in the result.
  - The most significant non-zero nibble index +1; 1 when the result is 0.
  - Updated on the same edge as outp; reset value 0.
  - Used for leading-zero blanking on displays.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then inp=8'd0, start 1 cycle -> done pulses WIDTH=8 cycles after the accepting edge; outp=12'h000; ndig=1 if enabled.
- inp=8'd255 -> outp=12'h255; inp=8'd99 -> outp=12'h099, ndig=2; inp=8'd100 -> outp=12'h100, ndig=3.
- WIDTH=4, DIGITS=2, sweep inp 0..15 -> outp equals the decimal value, e.g. 4'b1010 -> 8'h10 and 4'b1111 -> 8'h15; the lower 5 bits match the legacy combinational converter.
- Start pulsed again 3 cycles into a conversion with a different inp -> ignored; single done; result is the first operand.
- Start held high with inp=8'd37 then 8'd200 -> consecutive done pulses 9 cycles apart; outp=12'h037 then 12'h200; busy low only in the done cycles.
- rst asserted asynchronously mid-CONV (between edges) -> busy/done/outp go 0 immediately; no done afterwards; the next start converts normally.
